// File: rtl/fifo_verilog_pkg.sv
// -----------------------------------------------------------------------------
// fifo_verilog_pkg
// Purpose : Shared default sizes and the data word type for the fifo_verilog
//           byte FIFO and its storage sub-module.
// Contents: DEF_DATA_W  - default data width in bits
//           DEF_DEPTH   - default number of entries (power of two, >= 2)
//           DEF_ADDR_W  - pointer width, derived as log2(DEF_DEPTH)
//           data_t      - data word at the default width
// -----------------------------------------------------------------------------
package fifo_verilog_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 8;
   localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);

   typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Purpose : DEPTH x DATA_W storage array for fifo_verilog. Synchronous write
//           port and a registered read port. The array itself is never
//           cleared; only the read register is reset.
// Ports   : clk     - rising-edge clock
//           reset   - asynchronous active-low reset (clears o_rdata only)
//           i_we    - write strobe, i_wdata stored at i_waddr on the edge
//           i_waddr - write address
//           i_wdata - write data
//           i_re    - read strobe, entry at i_raddr loaded into o_rdata
//           i_raddr - read address
//           o_rdata - registered read data, holds when i_re is low
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_verilog_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Storage has no reset so it can map onto plain RAM/regfile cells.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_verilog.sv
// -----------------------------------------------------------------------------
// fifo_verilog
// Purpose : Single-clock FIFO of DEPTH words with registered read data and
//           full/empty flags decoded from a registered occupancy count.
//           Writes are dropped while full, reads are ignored while empty,
//           and an empty FIFO never falls through a same-cycle write.
// Ports   : clk       - rising-edge clock
//           reset     - asynchronous active-low reset
//           write_enb - write request, accepted when not full
//           read_enb  - read request, accepted when not empty
//           datain    - write data
//           dataout   - read data, valid the cycle after an accepted read
//           full      - FIFO holds DEPTH words
//           empty     - FIFO holds no words
//           overflow  - (FIFO_ERR_FLAGS_EN only) one-cycle pulse after a
//                       write attempted while full
//           underflow - (FIFO_ERR_FLAGS_EN only) one-cycle pulse after a
//                       read attempted while empty
// Build   : define FIFO_ERR_FLAGS_EN to add the overflow/underflow outputs.
// -----------------------------------------------------------------------------
module fifo_verilog
   import fifo_verilog_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_enb,
   input  logic              read_enb,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout,
   output logic              full,
   output logic              empty
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [ADDR_W-1:0] w_wr_ptr_nxt;
   logic [ADDR_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0]  w_count_nxt;

   // Flags come from the registered count, so a request is judged against
   // the occupancy before the edge (no bypass when full or empty).
   assign full  = (r_count == CNT_FULL);
   assign empty = (r_count == '0);

   assign w_wr_acc = write_enb & ~full;
   assign w_rd_acc = read_enb  & ~empty;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;

      // Pointers wrap for free because DEPTH is a power of two.
      if (w_wr_acc) begin
         w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
         w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
      end

      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (datain),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (dataout)
   );

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Rejected requests are flagged one cycle later, one pulse per attempt.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= write_enb & full;
         r_underflow <= read_enb  & empty;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_verilog.sv
// -----------------------------------------------------------------------------
// tb_fifo_verilog
// Purpose : Self-checking bench for fifo_verilog. A queue-based reference
//           model tracks the stored words, the expected read data and the
//           expected error pulses; directed scenarios are followed by
//           randomized traffic. Define FIFO_ERR_FLAGS_EN to cover the
//           overflow/underflow outputs as well.
// -----------------------------------------------------------------------------
module tb_fifo_verilog;
   import fifo_verilog_pkg::*;

   localparam int unsigned DEPTH = DEF_DEPTH;

   logic  clk;
   logic  reset;
   logic  write_enb;
   logic  read_enb;
   data_t datain;
   data_t dataout;
   logic  full;
   logic  empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic  overflow;
   logic  underflow;
`endif

   fifo_verilog dut (
      .clk       (clk),
      .reset     (reset),
      .write_enb (write_enb),
      .read_enb  (read_enb),
      .datain    (datain),
      .dataout   (dataout),
      .full      (full),
      .empty     (empty)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   data_t mq[$];
   data_t exp_dout;
   logic  exp_ovf;
   logic  exp_unf;

   int n_total;
   int n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".dout"},  32'(dataout), 32'(exp_dout));
      check({tag, ".full"},  32'(full),    32'(mq.size() == DEPTH));
      check({tag, ".empty"}, 32'(empty),   32'(mq.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
      check({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
      check({tag, ".unf"},   32'(underflow), 32'(exp_unf));
`endif
   endtask

   // Drive one cycle of requests, advance the model across the edge, and
   // compare shortly after the edge.
   task automatic do_cycle(input logic we, input logic re, input data_t din, input string tag);
      int occ;
      write_enb = we;
      read_enb  = re;
      datain    = din;
      @(posedge clk);
      if (!reset) begin
         mq.delete();
         exp_dout = '0;
         exp_ovf  = 1'b0;
         exp_unf  = 1'b0;
      end else begin
         occ     = mq.size();
         exp_ovf = we && (occ == DEPTH);
         exp_unf = re && (occ == 0);
         if (re && occ > 0)     exp_dout = mq.pop_front();
         if (we && occ < DEPTH) mq.push_back(din);
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      exp_dout  = '0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      write_enb = 1'b0;
      read_enb  = 1'b0;
      datain    = '0;
      reset     = 1'b0;

      // Reset held for two cycles, then released with enables low
      do_cycle(1'b0, 1'b0, 8'h00, "rst");
      do_cycle(1'b0, 1'b0, 8'h00, "rst");
      reset = 1'b1;
      do_cycle(1'b0, 1'b0, 8'h00, "rst_rel");

      // Six writes of 3, then six reads
      for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 8'd3, "wr6");
      for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 8'd0, "rd6");

      // Fill to capacity, drop a ninth write, drain in order
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, data_t'(8'h10 + i), "fill");
      do_cycle(1'b1, 1'b0, 8'hFF, "wr_full");
      do_cycle(1'b0, 1'b0, 8'h00, "idle_full");
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'h00, "drain");

      // Reads on an empty FIFO: dataout must hold 0x17
      do_cycle(1'b0, 1'b1, 8'h00, "rd_empty");
      do_cycle(1'b0, 1'b0, 8'h00, "rd_empty_idle");
      // Simultaneous request while empty: only the write lands
      do_cycle(1'b1, 1'b1, 8'h5A, "rw_empty");
      do_cycle(1'b0, 1'b1, 8'h00, "rw_empty_rd");

      // Hold four words and stream through with both enables (wraps pointers)
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, data_t'(8'h40 + i), "pre4");
      for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, data_t'(8'h80 + i), "rw4");
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, data_t'(8'hC0 + i), "top_up");
      // Full with both enables: read only, occupancy drops to 7
      do_cycle(1'b1, 1'b1, 8'hEE, "rw_full");
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'h00, "drain7");

      // Randomized traffic, write-heavy then read-heavy to reach both ends
      for (int ph = 0; ph < 4; ph++) begin
         int pw;
         pw = (ph % 2 == 0) ? 75 : 25;
         for (int i = 0; i < 40 * (1 << DEF_ADDR_W); i++) begin
            do_cycle(logic'($urandom_range(0, 99) < pw),
                     logic'($urandom_range(0, 99) < (100 - pw)),
                     data_t'($urandom), "rand");
         end
      end

      // Asynchronous reset mid-stream with five words stored
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'h00, "pre_rst_drain");
      for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, data_t'(8'hA1 + i), "pre_rst_wr");
      do_cycle(1'b0, 1'b1, 8'h00, "pre_rst_rd");
      check("pre_rst.count5", 32'(mq.size()), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      mq.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      check_outputs("async_rst");
      do_cycle(1'b0, 1'b0, 8'h00, "async_rst_hold");
      reset = 1'b1;
      do_cycle(1'b0, 1'b1, 8'h00, "post_rst_rd");
      do_cycle(1'b1, 1'b0, 8'h77, "post_rst_wr");
      do_cycle(1'b0, 1'b1, 8'h00, "post_rst_rd2");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
